mix_cols: RTL and testbench



---
 rtl/mix_cols_if.sv | 18 +
 rtl/mix_cols.sv | 173 +++++++++++++++++
 tb/tb_mix_cols.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mix_cols_if.sv
// Handshake/data bundle between a mix_cols engine and its requester.
// With MIX_COLS_INV_EN defined the bundle also carries the inverse-mode select inv_in.
interface mix_cols_if;
  logic         start;
  logic [127:0] block_in;
  logic [127:0] result_out;
  logic         valid_out;
  logic         busy;
`ifdef MIX_COLS_INV_EN
  logic         inv_in;

  modport master (output start, block_in, inv_in, input result_out, valid_out, busy);
  modport slave  (input start, block_in, inv_in, output result_out, valid_out, busy);
`else
  modport master (output start, block_in, input result_out, valid_out, busy);
  modport slave  (input start, block_in, output result_out, valid_out, busy);
`endif
endinterface

// File: rtl/mix_cols.sv
// AES MixColumns engine: captures a 128-bit block on start and mixes COLS_PER_CYCLE columns per clock.
// Optional MIX_COLS_INV_EN adds inv_in, selecting the inverse transform on the same datapath.
module mix_cols #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic      clk_in,
  input logic      rst_in,
  mix_cols_if.slave io
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
    $error("mix_cols: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_t;

  // For COLS_PER_CYCLE=4 the step truncates to 0, so the counter simply stays at 0.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] acc_q, acc_d;
  logic [127:0] res_q, res_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         mode_w;

`ifdef MIX_COLS_INV_EN
  logic mode_q, mode_d;
  assign mode_w = mode_q;
`else
  assign mode_w = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  // Column packed with row r at bits [8r +: 8]. Each byte is scaled once into the
  // four coefficient slots (diagonal, +1, +2, +3 rows); inv only changes which multiples feed them.
  function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] ce [4];
    logic [7:0] cb [4];
    logic [7:0] cd [4];
    logic [7:0] cn [4];
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      x1[i] = a[8*i +: 8];
      x2[i] = xtime(x1[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      if (inv) begin
        ce[i] = x8[i] ^ x4[i] ^ x2[i];
        cb[i] = x8[i] ^ x2[i] ^ x1[i];
        cd[i] = x8[i] ^ x4[i] ^ x1[i];
        cn[i] = x8[i] ^ x1[i];
      end else begin
        ce[i] = x2[i];
        cb[i] = x2[i] ^ x1[i];
        cd[i] = x1[i];
        cn[i] = x1[i];
      end
    end
    for (int r = 0; r < 4; r++) begin
      b[8*r +: 8] = ce[r] ^ cb[(r+1)%4] ^ cd[(r+2)%4] ^ cn[(r+3)%4];
    end
    return b;
  endfunction

  logic [127:0] acc_mix;
  logic [1:0]   col_idx;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  always_comb begin
    acc_mix = acc_q;
    col_idx = '0;
    col_in  = '0;
    col_out = '0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_idx = cnt_q + 2'(j);
      for (int r = 0; r < 4; r++) begin
        col_in[8*r +: 8] = blk_q[32*r + 8*int'(col_idx) +: 8];
      end
      col_out = mix_col(col_in, mode_w);
      for (int r = 0; r < 4; r++) begin
        acc_mix[32*r + 8*int'(col_idx) +: 8] = col_out[8*r +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    acc_d   = acc_q;
    res_d   = res_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
`ifdef MIX_COLS_INV_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (io.start) begin
          blk_d   = io.block_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MIX;
`ifdef MIX_COLS_INV_EN
          mode_d  = io.inv_in;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      MIX: begin
        acc_d = acc_mix;
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) begin
          res_d   = acc_mix;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MIX_COLS_INV_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef MIX_COLS_INV_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign io.result_out = res_q;
  assign io.valid_out  = valid_q;
  assign io.busy       = busy_q;

endmodule

// File: tb/tb_mix_cols.sv
// Directed + random bench for mix_cols at COLS_PER_CYCLE = 1, 2 and 4 against a GF(2^8) matrix model.
module tb_mix_cols;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  localparam int PW [3] = '{1, 2, 4};

  always #5 clk = ~clk;

  mix_cols_if if_p1();
  mix_cols_if if_p2();
  mix_cols_if if_p4();

  mix_cols #(.COLS_PER_CYCLE(1)) u_p1 (.clk_in(clk), .rst_in(rst), .io(if_p1));
  mix_cols #(.COLS_PER_CYCLE(2)) u_p2 (.clk_in(clk), .rst_in(rst), .io(if_p2));
  mix_cols #(.COLS_PER_CYCLE(4)) u_p4 (.clk_in(clk), .rst_in(rst), .io(if_p4));

  logic         vo [3];
  logic         bo [3];
  logic [127:0] ro [3];
  assign vo[0] = if_p1.valid_out;  assign bo[0] = if_p1.busy;  assign ro[0] = if_p1.result_out;
  assign vo[1] = if_p2.valid_out;  assign bo[1] = if_p2.busy;  assign ro[1] = if_p2.result_out;
  assign vo[2] = if_p4.valid_out;  assign bo[2] = if_p4.busy;  assign ro[2] = if_p4.result_out;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // b[r][c] = sum_k M[r][k] * a[k][c]; M is circulant with first row fw/iv.
  function automatic logic [127:0] ref_mix(input logic [127:0] blk, input logic inv);
    logic [7:0] fw [4];
    logic [7:0] iv [4];
    logic [7:0] s, cf;
    logic [127:0] o;
    fw[0] = 8'd2;  fw[1] = 8'd3;  fw[2] = 8'd1;  fw[3] = 8'd1;
    iv[0] = 8'd14; iv[1] = 8'd11; iv[2] = 8'd13; iv[3] = 8'd9;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s = 8'h00;
        for (int k = 0; k < 4; k++) begin
          cf = inv ? iv[(k - r + 4) % 4] : fw[(k - r + 4) % 4];
          s = s ^ gmul(blk[(4*k + c)*8 +: 8], cf);
        end
        o[(4*r + c)*8 +: 8] = s;
      end
    end
    return o;
  endfunction

  // Columns given with row 0 in the most significant byte, as written in the column lists.
  function automatic logic [127:0] cols(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0] cc [4];
    logic [127:0] o;
    cc[0] = c0; cc[1] = c1; cc[2] = c2; cc[3] = c3;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[(4*r + c)*8 +: 8] = cc[c][31 - 8*r -: 8];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic s, input logic [127:0] b, input logic inv);
    case (d)
      0: begin
        if_p1.start = s; if_p1.block_in = b;
`ifdef MIX_COLS_INV_EN
        if_p1.inv_in = inv;
`endif
      end
      1: begin
        if_p2.start = s; if_p2.block_in = b;
`ifdef MIX_COLS_INV_EN
        if_p2.inv_in = inv;
`endif
      end
      default: begin
        if_p4.start = s; if_p4.block_in = b;
`ifdef MIX_COLS_INV_EN
        if_p4.inv_in = inv;
`endif
      end
    endcase
  endtask

  task automatic drive_all(input logic s, input logic [127:0] b, input logic inv);
    for (int d = 0; d < 3; d++) drive(d, s, b, inv);
  endtask

  // One start pulse to all three engines; observe 8 edges for latency, pulse width, busy span and result.
  task automatic run_block(input logic [127:0] blk, input logic inv, input logic [127:0] exp,
                           input string tag);
    int first [3];
    int nbusy [3];
    int nval  [3];
    int ovl   [3];
    logic [127:0] rv [3];
    for (int d = 0; d < 3; d++) begin
      first[d] = 0; nbusy[d] = 0; nval[d] = 0; ovl[d] = 0; rv[d] = '0;
    end
    drive_all(1'b1, blk, inv);
    tick();
    drive_all(1'b0, rnd128(), inv);
    for (int e = 1; e <= 8; e++) begin
      for (int d = 0; d < 3; d++) begin
        if (bo[d] === 1'b1) nbusy[d]++;
        if (vo[d] === 1'b1) begin
          nval[d]++;
          if (first[d] == 0) begin
            first[d] = e;
            rv[d] = ro[d];
          end
        end
        if (vo[d] === 1'b1 && bo[d] === 1'b1) ovl[d]++;
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_latency_p%0d", tag, PW[d]), 128'(first[d]), 128'(4 / PW[d] + 1));
      chk($sformatf("%s_valid_pulses_p%0d", tag, PW[d]), 128'(nval[d]), 128'd1);
      chk($sformatf("%s_busy_cycles_p%0d", tag, PW[d]), 128'(nbusy[d]), 128'(4 / PW[d]));
      chk($sformatf("%s_busy_valid_overlap_p%0d", tag, PW[d]), 128'(ovl[d]), 128'd0);
      chk($sformatf("%s_result_p%0d", tag, PW[d]), rv[d], exp);
    end
  endtask

  logic [127:0] blk_a, exp_a, blk_c6, blk_d4, exp_d4, r1, snap [3];
  int t, first, second, extra, chg [3], vhold [3];
  logic inv_r;

  initial begin
    blk_a  = cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c);
    exp_a  = cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8);
    blk_c6 = {16{8'hc6}};
    blk_d4 = cols(32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5);
    exp_d4 = cols(32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6);

    rst = 1'b1;
    drive_all(1'b0, '0, 1'b0);
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_valid_p%0d", PW[d]), 128'(vo[d]), 128'd0);
      chk($sformatf("reset_busy_p%0d", PW[d]), 128'(bo[d]), 128'd0);
      chk($sformatf("reset_result_p%0d", PW[d]), ro[d], 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Known-answer block on all three widths.
    run_block(blk_a, 1'b0, exp_a, "ka");

    // Result must hold while idle.
    for (int d = 0; d < 3; d++) begin
      snap[d] = ro[d]; chg[d] = 0; vhold[d] = 0;
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        if (ro[d] !== snap[d]) chg[d]++;
        if (vo[d] !== 1'b0) vhold[d]++;
      end
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("hold_result_changes_p%0d", PW[d]), 128'(chg[d]), 128'd0);
      chk($sformatf("hold_valid_p%0d", PW[d]), 128'(vhold[d]), 128'd0);
    end

    // Back-to-back on P=1 with an ignored start during MIX.
    r1 = rnd128();
    drive(0, 1'b1, r1, 1'b0);
    tick();
    drive(0, 1'b0, rnd128(), 1'b0);
    tick();
    drive(0, 1'b1, rnd128(), 1'b0);
    tick();
    drive(0, 1'b0, rnd128(), 1'b0);
    t = 3;
    first = 0;
    while (t < 12 && first == 0) begin
      if (vo[0] === 1'b1) first = t;
      else begin tick(); t++; end
    end
    chk("b2b_first_latency", 128'(first), 128'd5);
    chk("b2b_first_result", ro[0], ref_mix(r1, 1'b0));
    drive(0, 1'b1, blk_c6, 1'b0);
    tick();
    drive(0, 1'b0, rnd128(), 1'b0);
    t = 1;
    second = 0;
    while (t < 12 && second == 0) begin
      if (vo[0] === 1'b1) second = t;
      else begin tick(); t++; end
    end
    chk("b2b_second_spacing", 128'(second), 128'd5);
    chk("b2b_second_result", ro[0], blk_c6);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vo[0] === 1'b1) extra++;
    end
    chk("b2b_no_extra_valid", 128'(extra), 128'd0);

    // Asynchronous reset two cycles into MIX.
    drive_all(1'b1, rnd128(), 1'b0);
    tick();
    drive_all(1'b0, rnd128(), 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("arst_valid_p%0d", PW[d]), 128'(vo[d]), 128'd0);
      chk($sformatf("arst_busy_p%0d", PW[d]), 128'(bo[d]), 128'd0);
      chk($sformatf("arst_result_p%0d", PW[d]), ro[d], 128'd0);
    end
    tick();
    tick();
    #2;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) vhold[d] = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      for (int d = 0; d < 3; d++) if (vo[d] !== 1'b0 || bo[d] !== 1'b0) vhold[d]++;
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("arst_no_valid_after_p%0d", PW[d]), 128'(vhold[d]), 128'd0);
    run_block(blk_d4, 1'b0, exp_d4, "post_reset");

    // Random blocks against the matrix model.
    for (int i = 0; i < 6; i++) begin
      r1 = rnd128();
`ifdef MIX_COLS_INV_EN
      inv_r = 1'($urandom_range(0, 1));
`else
      inv_r = 1'b0;
`endif
      run_block(r1, inv_r, ref_mix(r1, inv_r), $sformatf("rand%0d", i));
    end

`ifdef MIX_COLS_INV_EN
    run_block(exp_a, 1'b1, blk_a, "inv_roundtrip");
    run_block(blk_a, 1'b0, exp_a, "fwd_with_inv_port");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
